// File: rtl/decoder_1x2_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decoder_1x2_pkg : shared decoder constants and the binary-to-one-hot helper
// Revision        : 1.0
// ----------------------------------------------------------------------------
package decoder_1x2_pkg;

   localparam int DEC_MAX_SEL_W = 6;
   localparam int DEC_MAX_OUT_W = 1 << DEC_MAX_SEL_W;

   // Result is full width; callers keep the low 2**SEL_W bits.
   function automatic logic [DEC_MAX_OUT_W-1:0] onehot_decode(
      input logic [DEC_MAX_SEL_W-1:0] sel,
      input logic                     en
   );
      logic [DEC_MAX_OUT_W-1:0] raw;
      raw = '0;
      if (en) raw[sel] = 1'b1;
      return raw;
   endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_1x2_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decoder_1x2_if : select request and decoded enable lines of the decoder
// Revision       : 1.0
// ----------------------------------------------------------------------------
interface decoder_1x2_if #(
   parameter int SEL_W = 1
) ();

   logic                  en;
   logic [SEL_W-1:0]      sel;
   logic [(1<<SEL_W)-1:0] y;
   logic                  y0;
   logic                  y1;
   logic                  valid;

   modport master (
      output en,
      output sel,
      input  y,
      input  y0,
      input  y1,
      input  valid
   );

   modport slave (
      input  en,
      input  sel,
      output y,
      output y0,
      output y1,
      output valid
   );

endinterface
`default_nettype wire

// File: rtl/decoder_1x2_out_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decoder_out_stage : polarity, valid flag and optional output flop bank
// Revision          : 1.0
// ----------------------------------------------------------------------------
module decoder_out_stage #(
   parameter int WIDTH       = 2,
   parameter int REGISTERED  = 0,
   parameter int ACTIVE_HIGH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] raw,
   input  logic             en,
   output logic [WIDTH-1:0] y,
   output logic             valid
);

   localparam logic [WIDTH-1:0] IDLE_VAL = (ACTIVE_HIGH != 0) ? {WIDTH{1'b0}} : {WIDTH{1'b1}};

   logic [WIDTH-1:0] y_d;
   logic             valid_d;

   always_comb begin
      y_d     = (ACTIVE_HIGH != 0) ? raw : ~raw;
      valid_d = en;
   end

   generate
      if (REGISTERED != 0) begin : g_reg
         logic [WIDTH-1:0] y_q;
         logic             valid_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               y_q     <= IDLE_VAL;
               valid_q <= 1'b0;
            end else begin
               y_q     <= y_d;
               valid_q <= valid_d;
            end
         end

         assign y     = y_q;
         assign valid = valid_q;
      end else begin : g_comb
         // Clock and reset have no function in the combinational build.
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst_n;

         assign y     = y_d;
         assign valid = valid_d;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/decoder_1x2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decoder_1x2 : binary select to one-hot enable decoder with y0/y1 aliases
// Revision    : 1.0
// ----------------------------------------------------------------------------
module decoder_1x2
   import decoder_1x2_pkg::*;
#(
   parameter int SEL_W       = 1,
   parameter int REGISTERED  = 0,
   parameter int ACTIVE_HIGH = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   decoder_1x2_if.slave  bus
);

   localparam int OUT_W = 1 << SEL_W;

   logic [DEC_MAX_SEL_W-1:0] sel_ext;
   logic [DEC_MAX_OUT_W-1:0] dec_full;
   logic [OUT_W-1:0]         raw;
   logic [OUT_W-1:0]         y_int;
   logic                     valid_int;

   always_comb begin
      sel_ext              = '0;
      sel_ext[SEL_W-1:0]   = bus.sel;
   end

   assign dec_full = onehot_decode(sel_ext, bus.en);
   assign raw      = dec_full[OUT_W-1:0];

   generate
      if (OUT_W < DEC_MAX_OUT_W) begin : g_trim
         logic unused_dec_bits;
         assign unused_dec_bits = |dec_full[DEC_MAX_OUT_W-1:OUT_W];
      end
   endgenerate

   decoder_out_stage #(
      .WIDTH       (OUT_W),
      .REGISTERED  (REGISTERED),
      .ACTIVE_HIGH (ACTIVE_HIGH)
   ) u_out_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw),
      .en    (bus.en),
      .y     (y_int),
      .valid (valid_int)
   );

   assign bus.y     = y_int;
   assign bus.y0    = y_int[0];
   assign bus.y1    = y_int[1];
   assign bus.valid = valid_int;

endmodule
`default_nettype wire

// File: tb/tb_decoder_1x2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_decoder_1x2 : directed vector bench over four decoder configurations
// Revision       : 1.0
// ----------------------------------------------------------------------------
module tb_decoder_1x2;
   import decoder_1x2_pkg::*;

   typedef struct {
      int         dut;      // 0 default, 1 active-low, 2 SEL_W=3
      logic       en;
      logic [2:0] sel;
      logic [7:0] exp_y;
      logic       exp_valid;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_bad;
   vec_t tbl[$];

   decoder_1x2_if #(.SEL_W(1)) if_def ();
   decoder_1x2_if #(.SEL_W(1)) if_low ();
   decoder_1x2_if #(.SEL_W(3)) if_w3  ();
   decoder_1x2_if #(.SEL_W(1)) if_reg ();

   decoder_1x2 #(.SEL_W(1), .REGISTERED(0), .ACTIVE_HIGH(1)) u_def (.clk(clk), .rst_n(rst_n), .bus(if_def));
   decoder_1x2 #(.SEL_W(1), .REGISTERED(0), .ACTIVE_HIGH(0)) u_low (.clk(clk), .rst_n(rst_n), .bus(if_low));
   decoder_1x2 #(.SEL_W(3), .REGISTERED(0), .ACTIVE_HIGH(1)) u_w3  (.clk(clk), .rst_n(rst_n), .bus(if_w3));
   decoder_1x2 #(.SEL_W(1), .REGISTERED(1), .ACTIVE_HIGH(1)) u_reg (.clk(clk), .rst_n(rst_n), .bus(if_reg));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_reg(input string name, input logic [1:0] exp_y, input logic exp_v);
      check(name, {6'b0, if_reg.y, if_reg.valid}, {6'b0, exp_y, exp_v});
      check({name, "_alias"}, {7'b0, if_reg.y1, if_reg.y0}, {7'b0, exp_y});
   endtask

   initial begin
      logic [8:0]  act;
      logic [63:0] model_full;
      n_vec = 0;
      n_bad = 0;
      rst_n = 1'b0;
      if_def.en = 1'b0; if_def.sel = '0;
      if_low.en = 1'b0; if_low.sel = '0;
      if_w3.en  = 1'b0; if_w3.sel  = '0;
      if_reg.en = 1'b0; if_reg.sel = '0;

      tbl.push_back('{0, 1'b1, 3'd0, 8'h01, 1'b1});
      tbl.push_back('{0, 1'b1, 3'd1, 8'h02, 1'b1});
      tbl.push_back('{0, 1'b0, 3'd0, 8'h00, 1'b0});
      tbl.push_back('{0, 1'b0, 3'd1, 8'h00, 1'b0});
      tbl.push_back('{1, 1'b1, 3'd0, 8'h02, 1'b1});
      tbl.push_back('{1, 1'b1, 3'd1, 8'h01, 1'b1});
      tbl.push_back('{1, 1'b0, 3'd0, 8'h03, 1'b0});
      tbl.push_back('{1, 1'b0, 3'd1, 8'h03, 1'b0});
      tbl.push_back('{2, 1'b1, 3'd0, 8'h01, 1'b1});
      tbl.push_back('{2, 1'b1, 3'd1, 8'h02, 1'b1});
      tbl.push_back('{2, 1'b1, 3'd2, 8'h04, 1'b1});
      tbl.push_back('{2, 1'b1, 3'd3, 8'h08, 1'b1});
      tbl.push_back('{2, 1'b1, 3'd4, 8'h10, 1'b1});
      tbl.push_back('{2, 1'b1, 3'd5, 8'h20, 1'b1});
      tbl.push_back('{2, 1'b1, 3'd6, 8'h40, 1'b1});
      tbl.push_back('{2, 1'b1, 3'd7, 8'h80, 1'b1});
      tbl.push_back('{2, 1'b0, 3'd5, 8'h00, 1'b0});

      // Registered copy holds reset values while rst_n is low
      repeat (2) @(negedge clk);
      #1;
      check_reg("reg_reset", 2'b00, 1'b0);

      foreach (tbl[i]) begin
         @(negedge clk);
         case (tbl[i].dut)
            0:       begin if_def.en = tbl[i].en; if_def.sel = tbl[i].sel[0]; end
            1:       begin if_low.en = tbl[i].en; if_low.sel = tbl[i].sel[0]; end
            default: begin if_w3.en  = tbl[i].en; if_w3.sel  = tbl[i].sel;    end
         endcase
         #1;
         case (tbl[i].dut)
            0: begin
               act = {6'b0, if_def.y, if_def.valid};
               check($sformatf("vec%0d_alias", i), {7'b0, if_def.y1, if_def.y0}, {7'b0, tbl[i].exp_y[1:0]});
            end
            1: begin
               act = {6'b0, if_low.y, if_low.valid};
               check($sformatf("vec%0d_alias", i), {7'b0, if_low.y1, if_low.y0}, {7'b0, tbl[i].exp_y[1:0]});
            end
            default: begin
               act = {if_w3.y, if_w3.valid};
               model_full = onehot_decode({3'b0, tbl[i].sel}, tbl[i].en);
               check($sformatf("vec%0d_model", i), {1'b0, if_w3.y}, {1'b0, model_full[7:0]});
               check($sformatf("vec%0d_ones", i), {8'b0, ($countones(if_w3.y) == 1)}, {8'b0, tbl[i].en});
               check($sformatf("vec%0d_alias", i), {7'b0, if_w3.y1, if_w3.y0}, {7'b0, tbl[i].exp_y[1:0]});
            end
         endcase
         check($sformatf("vec%0d", i), act, {tbl[i].exp_y, tbl[i].exp_valid});
      end

      // Reset release is synchronous: nothing loads until the next edge
      @(negedge clk);
      if_reg.en = 1'b1; if_reg.sel = 1'b0; rst_n = 1'b1;
      #1; check_reg("reg_release_hold", 2'b00, 1'b0);
      @(posedge clk); #1; check_reg("reg_first_load", 2'b01, 1'b1);

      @(negedge clk); if_reg.sel = 1'b1;
      #1; check_reg("reg_latency", 2'b01, 1'b1);
      @(posedge clk); #1; check_reg("reg_sel1", 2'b10, 1'b1);
      @(negedge clk); if_reg.sel = 1'b0;
      @(posedge clk); #1; check_reg("reg_sel0", 2'b01, 1'b1);
      @(negedge clk); if_reg.sel = 1'b1;
      @(posedge clk); #1; check_reg("reg_sel1b", 2'b10, 1'b1);

      // Asynchronous reset mid-cycle clears outputs without a clock edge
      #2; rst_n = 1'b0;
      #1; check_reg("reg_async_rst", 2'b00, 1'b0);
      @(posedge clk); #1; check_reg("reg_rst_held", 2'b00, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      #1; check_reg("reg_rst_release", 2'b00, 1'b0);
      @(posedge clk); #1; check_reg("reg_after_rst", 2'b10, 1'b1);

      @(negedge clk); if_reg.en = 1'b0;
      @(posedge clk); #1; check_reg("reg_en0", 2'b00, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
